// File: rtl/accel_csr_pkg.sv
// rtl/accel_csr_pkg.sv - shared AXI response codes and CSR bridge state type
package accel_csr_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      WR_STB,
      WR_RSP,
      RD_STB,
      RD_RSP
   } bridge_state_t;

   typedef enum logic {
      GRANT_READ  = 1'b0,
      GRANT_WRITE = 1'b1
   } grant_t;

endpackage

// File: rtl/axil_hold_slot.sv
// rtl/axil_hold_slot.sv - one-entry valid/ready holding register for an AXI-Lite channel
module axil_hold_slot #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_take
);

   logic         full;
   logic [W-1:0] data_q;

   // A take is only issued while full, and a load only while empty, so they never collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full   <= 1'b0;
         data_q <= '0;
      end else if (out_take) begin
         full <= 1'b0;
      end else if (in_valid && !full) begin
         full   <= 1'b1;
         data_q <= in_data;
      end
   end

   assign in_ready  = !full;
   assign out_valid = full;
   assign out_data  = data_q;

endmodule

// File: rtl/axil_csr_bridge.sv
// rtl/axil_csr_bridge.sv - AXI4-Lite slave driving single-cycle CSR read/write strobes
module axil_csr_bridge
   import accel_csr_pkg::*;
#(
   parameter int AXI_ADDR_W = 32,
   parameter int ADDR_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic                  csr_wen,
   output logic                  csr_ren,
   output logic [ADDR_W-1:0]     csr_addr,
   output logic [31:0]           csr_wdata,
   input  logic [31:0]           csr_rdata
);

   bridge_state_t state, state_d;
   grant_t        last_grant;

   logic [ADDR_W-1:0] aw_addr, ar_addr;
   logic [35:0]       w_bundle;
   logic              aw_full, w_full, ar_full;
   logic              aw_take, w_take, ar_take;
   logic              wr_elig, rd_elig, grant_wr, grant_rd, wr_err, rd_err;

   // Upper address bits alias onto the 256 B map and are deliberately dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{s_axi_awaddr[AXI_ADDR_W-1:ADDR_W], s_axi_araddr[AXI_ADDR_W-1:ADDR_W]};

   axil_hold_slot #(.W(ADDR_W)) u_aw_slot (
      .clk(clk), .rst_n(rst_n),
      .in_data(s_axi_awaddr[ADDR_W-1:0]), .in_valid(s_axi_awvalid), .in_ready(s_axi_awready),
      .out_data(aw_addr), .out_valid(aw_full), .out_take(aw_take)
   );

   axil_hold_slot #(.W(36)) u_w_slot (
      .clk(clk), .rst_n(rst_n),
      .in_data({s_axi_wstrb, s_axi_wdata}), .in_valid(s_axi_wvalid), .in_ready(s_axi_wready),
      .out_data(w_bundle), .out_valid(w_full), .out_take(w_take)
   );

   axil_hold_slot #(.W(ADDR_W)) u_ar_slot (
      .clk(clk), .rst_n(rst_n),
      .in_data(s_axi_araddr[ADDR_W-1:0]), .in_valid(s_axi_arvalid), .in_ready(s_axi_arready),
      .out_data(ar_addr), .out_valid(ar_full), .out_take(ar_take)
   );

   assign wr_elig  = aw_full && w_full;
   assign rd_elig  = ar_full;
   assign grant_wr = wr_elig && (!rd_elig || last_grant == GRANT_READ);
   assign grant_rd = rd_elig && !grant_wr;
   assign wr_err   = (aw_addr[1:0] != 2'b00) || (w_bundle[35:32] != 4'hF);
   assign rd_err   = (ar_addr[1:0] != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      aw_take = 1'b0;
      w_take  = 1'b0;
      ar_take = 1'b0;
      case (state)
         IDLE: begin
            if (grant_wr) begin
               state_d = WR_STB;
               aw_take = 1'b1;
               w_take  = 1'b1;
            end else if (grant_rd) begin
               state_d = RD_STB;
               ar_take = 1'b1;
            end
         end
         WR_STB:  state_d = WR_RSP;
         WR_RSP:  if (s_axi_bready) state_d = IDLE;
         RD_STB:  state_d = RD_RSP;
         RD_RSP:  if (s_axi_rready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes are registered so the CSR block sees clean single-cycle pulses for clock gating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant  <= GRANT_READ;
         csr_wen     <= 1'b0;
         csr_ren     <= 1'b0;
         csr_addr    <= '0;
         csr_wdata   <= '0;
         s_axi_bresp <= AXI_RESP_OKAY;
         s_axi_rresp <= AXI_RESP_OKAY;
         s_axi_rdata <= '0;
      end else begin
         csr_wen <= 1'b0;
         csr_ren <= 1'b0;
         if (state == IDLE && grant_wr) begin
            last_grant  <= GRANT_WRITE;
            s_axi_bresp <= wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            if (!wr_err) begin
               csr_wen   <= 1'b1;
               csr_addr  <= aw_addr;
               csr_wdata <= w_bundle[31:0];
            end
         end
         if (state == IDLE && grant_rd) begin
            last_grant  <= GRANT_READ;
            s_axi_rresp <= rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            if (!rd_err) begin
               csr_ren  <= 1'b1;
               csr_addr <= ar_addr;
            end
         end
         // csr_ren is high in RD_STB exactly when the read was legal.
         if (state == RD_STB) s_axi_rdata <= csr_ren ? csr_rdata : 32'h0;
      end
   end

   assign s_axi_bvalid = (state == WR_RSP);
   assign s_axi_rvalid = (state == RD_RSP);

endmodule
